dmem_arbiter: RTL and testbench

//  Shares the single-ported 16-bit data memory between the CPU MEM stage (port 0) and the DMA/loader engine (port 1).

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 24 ++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared constants and types for the data-memory arbiter.
// Revision: 1.0
// ============================================================================
package dmem_pkg;

    localparam int DMEM_AW = 16;
    localparam int DMEM_DW = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [0:0] {
        ARB_CPU_PRI   = 1'b0,
        ARB_DMA_FORCE = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter_if
// Brief   : Requester-side bus of the data-memory arbiter (one per port).
// Revision: 1.0
// ============================================================================
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : CPU-priority arbiter for the single-ported data memory with
//           DMA starvation guard and one-cycle read return.
// Revision: 1.0
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW         = DMEM_AW,
    parameter int DW         = DMEM_DW,
    parameter int STARVE_MAX = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dmem_arbiter_if.slave      cpu_bus,
    dmem_arbiter_if.slave      dma_bus,
    output logic [AW-1:0]      mem_addr_o,
    output logic               mem_re_o,
    output logic               mem_we_o,
    output logic [DW-1:0]      mem_wdata_o,
    input  wire logic [DW-1:0] mem_rd_data_i
);

    localparam logic [3:0] c_starve_last = 4'(STARVE_MAX - 1);

    arb_state_e    state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic [1:0]    rd_pend_q;          // {valid, port id}
    logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic          w_cpu_gnt, w_dma_gnt, w_any_gnt, w_win_we, w_rd_gnt;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;

    // Grants are suppressed while reset is asserted so every output reads 0.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (!rst) begin
            if (state_q == ARB_DMA_FORCE) begin
                w_dma_gnt = dma_bus.req;
                w_cpu_gnt = cpu_bus.req & ~dma_bus.req;
            end else begin
                w_cpu_gnt = cpu_bus.req;
                w_dma_gnt = dma_bus.req & ~cpu_bus.req;
            end
        end
    end

    assign w_any_gnt   = w_cpu_gnt | w_dma_gnt;
    assign w_win_we    = w_dma_gnt ? dma_bus.we    : cpu_bus.we;
    assign w_win_addr  = w_dma_gnt ? dma_bus.addr  : cpu_bus.addr;
    assign w_win_wdata = w_dma_gnt ? dma_bus.wdata : cpu_bus.wdata;
    assign w_rd_gnt    = w_any_gnt & ~w_win_we;

    always_comb begin
        state_d  = state_q;
        starve_d = 4'd0;
        if (dma_bus.req && !w_dma_gnt) begin
            starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
        end
        case (state_q)
            ARB_CPU_PRI: begin
                if (dma_bus.req && !w_dma_gnt && starve_q == c_starve_last) begin
                    state_d = ARB_DMA_FORCE;
                end
            end
            default: begin
                if (w_dma_gnt || !dma_bus.req) begin
                    state_d = ARB_CPU_PRI;
                end
            end
        endcase
    end

    // Memory latches read data while clk is low, so it is stable at the
    // posedge closing the grant cycle and is captured there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_CPU_PRI;
            starve_q    <= 4'd0;
            rd_pend_q   <= 2'b00;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            rd_pend_q <= {w_rd_gnt, w_dma_gnt};
            if (w_rd_gnt && w_cpu_gnt) begin
                cpu_rdata_q <= mem_rd_data_i;
            end
            if (w_rd_gnt && w_dma_gnt) begin
                dma_rdata_q <= mem_rd_data_i;
            end
            if (w_any_gnt) begin
                addr_q  <= w_win_addr;
                wdata_q <= w_win_wdata;
            end
        end
    end

    assign cpu_bus.gnt    = w_cpu_gnt;
    assign dma_bus.gnt    = w_dma_gnt;
    assign cpu_bus.rvalid = rd_pend_q[1] & (rd_pend_q[0] == PORT_CPU);
    assign dma_bus.rvalid = rd_pend_q[1] & (rd_pend_q[0] == PORT_DMA);
    assign cpu_bus.rdata  = cpu_rdata_q;
    assign dma_bus.rdata  = dma_rdata_q;

    // Idle cycles keep the last winner's address/data to avoid bus toggling.
    assign mem_addr_o  = w_any_gnt ? w_win_addr  : addr_q;
    assign mem_wdata_o = w_any_gnt ? w_win_wdata : wdata_q;
    assign mem_re_o    = w_rd_gnt;
    assign mem_we_o    = w_any_gnt & w_win_we;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Self-checking bench for dmem_arbiter with a behavioural memory
//           and a rule-level arbitration/return model.
// Revision: 1.0
// ============================================================================
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rd_data = '0;
    logic        mem_re, mem_we;

    dmem_arbiter_if #(.AW(16), .DW(16)) cpu_if ();
    dmem_arbiter_if #(.AW(16), .DW(16)) dma_if ();

    dmem_arbiter #(.AW(16), .DW(16), .STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_bus      (cpu_if),
        .dma_bus      (dma_if),
        .mem_addr_o   (mem_addr),
        .mem_re_o     (mem_re),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .mem_rd_data_i(mem_rd_data)
    );

    always #5 clk = ~clk;

    bit [15:0] mem [65536];
    always @(negedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (mem_re) mem_rd_data = mem[mem_addr];
    end

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    int          denied;
    logic        m_cpu, m_dma, last_dgnt;
    logic        exp_cv, exp_dv;
    logic [15:0] exp_cd, exp_dd, last_addr, last_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        denied = 0; exp_cv = 0; exp_dv = 0; exp_cd = '0; exp_dd = '0;
        last_addr = '0; last_wdata = '0;
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        cpu_if.req = r; cpu_if.we = w; cpu_if.addr = a; cpu_if.wdata = d;
    endtask

    task automatic set_dma(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        dma_if.req = r; dma_if.we = w; dma_if.addr = a; dma_if.wdata = d;
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic run_cycle();
        logic        ww, any;
        logic [15:0] wa, wd;
        #1;
        if (rst) begin
            m_cpu = 1'b0; m_dma = 1'b0;
        end else begin
            m_dma = dma_if.req && (!cpu_if.req || denied >= STARVE_MAX);
            m_cpu = cpu_if.req && !m_dma;
        end
        any = m_cpu | m_dma;
        ww  = m_dma ? dma_if.we    : cpu_if.we;
        wa  = m_dma ? dma_if.addr  : cpu_if.addr;
        wd  = m_dma ? dma_if.wdata : cpu_if.wdata;
        last_dgnt = dma_if.gnt;
        chk("cpu_gnt", cpu_if.gnt, m_cpu);
        chk("dma_gnt", dma_if.gnt, m_dma);
        chk("re_we_excl", mem_re & mem_we, 0);
        chk("mem_re", mem_re, any & ~ww);
        chk("mem_we", mem_we, any & ww);
        chk("mem_addr", mem_addr, any ? wa : last_addr);
        chk("mem_wdata", mem_wdata, any ? wd : last_wdata);
        chk("cpu_rvalid", cpu_if.rvalid, exp_cv);
        chk("cpu_rdata", cpu_if.rdata, exp_cd);
        chk("dma_rvalid", dma_if.rvalid, exp_dv);
        chk("dma_rdata", dma_if.rdata, exp_dd);
        if (rst) begin
            model_reset();
        end else begin
            exp_cv = m_cpu && !ww;
            exp_dv = m_dma && !ww;
            if (exp_cv) exp_cd = mem[wa];
            if (exp_dv) exp_dd = mem[wa];
            denied = (dma_if.req && !m_dma) ? denied + 1 : 0;
            if (any) begin
                last_addr  = wa;
                last_wdata = wd;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5C3;
        model_reset();
        m_cpu = 0; m_dma = 0; last_dgnt = 0;

        // 1: reset with both requesting, then CPU wins first
        set_cpu(1, 0, 16'h0001, 16'h0);
        set_dma(1, 0, 16'h0002, 16'h0);
        @(posedge clk); #1;
        run_cycle();
        run_cycle();
        rst = 1'b0;
        run_cycle();
        set_cpu(0, 0, 16'h0001, 16'h0);
        run_cycle();
        set_dma(0, 0, 16'h0002, 16'h0);
        run_cycle();

        // 2: write then read same address
        set_cpu(1, 1, 16'h0010, 16'hBEEF);
        run_cycle();
        set_cpu(1, 0, 16'h0010, 16'h0);
        run_cycle();
        set_cpu(0, 0, 16'h0010, 16'h0);
        #1;
        chk("raw_rvalid", cpu_if.rvalid, 1);
        chk("raw_rdata", cpu_if.rdata, 16'hBEEF);
        run_cycle();

        // 3: both requesting continuously -> 4 CPU grants then 1 DMA grant
        set_cpu(1, 0, 16'h0020, 16'h0);
        set_dma(1, 0, 16'h0030, 16'h0);
        for (int i = 0; i < 15; i++) begin
            run_cycle();
            chk("starve_pattern", last_dgnt, (i % 5) == 4);
        end
        set_dma(0, 0, 16'h0030, 16'h0);
        run_cycle();
        set_cpu(0, 0, 16'h0020, 16'h0);
        run_cycle();

        // 4: DMA-only back-to-back reads
        for (int k = 0; k < 5; k++) begin
            if (k < 4) set_dma(1, 0, 16'h0100 + 16'(k), 16'h0);
            else       set_dma(0, 0, 16'h0103, 16'h0);
            if (k > 0) begin
                chk("dma_b2b_rvalid", dma_if.rvalid, 1);
                chk("dma_b2b_rdata", dma_if.rdata, (16'h0100 + 16'(k - 1)) ^ 16'hA5C3);
            end
            run_cycle();
        end

        // 5: alternating CPU / DMA reads
        for (int j = 0; j < 6; j++) begin
            if (j % 2 == 0) begin
                set_cpu(1, 0, 16'h0040 + 16'(j), 16'h0);
                set_dma(0, 0, 16'h0, 16'h0);
            end else begin
                set_cpu(0, 0, 16'h0, 16'h0);
                set_dma(1, 0, 16'h0040 + 16'(j), 16'h0);
            end
            run_cycle();
        end
        set_dma(0, 0, 16'h0, 16'h0);
        run_cycle();

        // 6: partial DMA starvation, then reset between read grant and return
        set_cpu(1, 0, 16'h0011, 16'h0);
        set_dma(1, 0, 16'h0012, 16'h0);
        repeat (3) run_cycle();
        #1;
        chk("rst_mid_gnt", cpu_if.gnt, 1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_re", mem_re, 0);
        @(posedge clk); #1;
        chk("rst_mid_rvalid", cpu_if.rvalid, 0);
        run_cycle();
        rst = 1'b0;
        repeat (6) run_cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (!cpu_if.req || m_cpu)
                set_cpu(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 63)), 16'($urandom));
            if (!dma_if.req || m_dma)
                set_dma(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 63)), 16'($urandom));
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
